// File: rtl/fp_flag_collect.sv
// fp_flag_collect: gathers FP exception flags from lanes u1/u3/u5 at writeback,
// holds them per ROB entry and merges them into the sticky fflags register in
// program order at retire. The oldest retiring entry with a trap request
// raises a one-cycle precise-trap pulse; younger slots in that group are dropped.
module fp_flag_collect #(
   parameter int unsigned ROB_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             u1_en,
   input  logic [ROB_W-1:0] u1_rob,
   input  logic [5:0]       u1_flg,
   input  logic             u3_en,
   input  logic [ROB_W-1:0] u3_rob,
   input  logic [5:0]       u3_flg,
   input  logic             u5_en,
   input  logic [ROB_W-1:0] u5_rob,
   input  logic [5:0]       u5_flg,
   input  logic [2:0]       ret_en,
   input  logic [ROB_W-1:0] ret_rob0,
   input  logic [ROB_W-1:0] ret_rob1,
   input  logic [ROB_W-1:0] ret_rob2,
   input  logic             flush,
   input  logic             csr_wr,
   input  logic [4:0]       csr_wdata,
   output logic [4:0]       fflags,
   output logic             exc_valid,
   output logic [ROB_W-1:0] exc_rob
);

   localparam int unsigned DEPTH = 2 ** ROB_W;

   // Lane and retire-slot views as arrays
   logic [2:0]       ln_en;
   logic [ROB_W-1:0] ln_rob  [3];
   logic [5:0]       ln_flg  [3];
   logic [ROB_W-1:0] ret_rob [3];

   // S1 capture register
   logic [2:0]       s1_en_q;
   logic [ROB_W-1:0] s1_rob_q [3];
   logic [5:0]       s1_flg_q [3];

   // Per-entry flag table
   logic [DEPTH-1:0] tbl_vld_q, tbl_vld_d;
   logic [5:0]       tbl_flg_q [DEPTH];
   logic [5:0]       tbl_flg_d [DEPTH];

   // Retire lookup and merge results
   logic [5:0]       eff_flg [3];
   logic [5:0]       byp_flg [3];
   logic [2:0]       byp_hit;
   logic [5:0]       acc_flg;
   logic             trap;
   logic [ROB_W-1:0] trap_rob;

   logic [4:0]       fflags_q, fflags_d;
   logic             exc_valid_q;
   logic [ROB_W-1:0] exc_rob_q, exc_rob_d;

   // Gather the discrete lane and slot ports into arrays
   always_comb begin
      ln_en      = {u5_en, u3_en, u1_en};
      ln_rob[0]  = u1_rob;
      ln_rob[1]  = u3_rob;
      ln_rob[2]  = u5_rob;
      ln_flg[0]  = u1_flg;
      ln_flg[1]  = u3_flg;
      ln_flg[2]  = u5_flg;
      ret_rob[0] = ret_rob0;
      ret_rob[1] = ret_rob1;
      ret_rob[2] = ret_rob2;
   end

   // S1 capture; flush drops anything arriving in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_en_q <= '0;
         for (int l = 0; l < 3; l++) begin
            s1_rob_q[l] <= '0;
            s1_flg_q[l] <= '0;
         end
      end else begin
         s1_en_q <= flush ? 3'b000 : ln_en;
         for (int l = 0; l < 3; l++) begin
            s1_rob_q[l] <= ln_rob[l];
            s1_flg_q[l] <= ln_flg[l];
         end
      end
   end

   // Per-slot lookup: S1 bypass is newer than the table, so it wins outright
   always_comb begin
      for (int s = 0; s < 3; s++) begin
         byp_hit[s] = 1'b0;
         byp_flg[s] = '0;
         for (int l = 0; l < 3; l++) begin
            if (s1_en_q[l] && (s1_rob_q[l] == ret_rob[s])) begin
               byp_hit[s] = 1'b1;
               byp_flg[s] = byp_flg[s] | s1_flg_q[l];
            end
         end
         if (byp_hit[s]) begin
            eff_flg[s] = byp_flg[s];
         end else if (tbl_vld_q[ret_rob[s]]) begin
            eff_flg[s] = tbl_flg_q[ret_rob[s]];
         end else begin
            eff_flg[s] = '0;
         end
      end
   end

   // Oldest-first merge; the first trapping slot is included, later ones dropped
   always_comb begin
      acc_flg  = '0;
      trap     = 1'b0;
      trap_rob = '0;
      for (int s = 0; s < 3; s++) begin
         if (ret_en[s] && !trap) begin
            acc_flg = acc_flg | eff_flg[s];
            if (eff_flg[s][5]) begin
               trap     = 1'b1;
               trap_rob = ret_rob[s];
            end
         end
      end
   end

   // Table next state: flush > S1 write > retire clear
   always_comb begin
      tbl_vld_d = tbl_vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         tbl_flg_d[i] = tbl_flg_q[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
         for (int s = 0; s < 3; s++) begin
            if (ret_en[s] && (ret_rob[s] == ROB_W'(i))) begin
               tbl_vld_d[i] = 1'b0;
            end
         end
      end
      // Colliding lanes OR together; the first hit replaces stale contents
      for (int l = 0; l < 3; l++) begin
         if (s1_en_q[l]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (s1_rob_q[l] == ROB_W'(i)) begin
                  tbl_flg_d[i] = byp_merge(l, i);
                  tbl_vld_d[i] = 1'b1;
               end
            end
         end
      end
      if (flush) begin
         tbl_vld_d = '0;
      end
   end

   // OR of every valid S1 lane targeting entry idx (lane l is known to hit)
   function automatic logic [5:0] byp_merge(input int l, input int idx);
      logic [5:0] m;
      m = '0;
      for (int k = 0; k < 3; k++) begin
         if (s1_en_q[k] && (s1_rob_q[k] == ROB_W'(idx))) begin
            m = m | s1_flg_q[k];
         end
      end
      return (l >= 0) ? m : '0;
   endfunction

   // Table state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tbl_vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_flg_q[i] <= '0;
         end
      end else begin
         tbl_vld_q <= tbl_vld_d;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_flg_q[i] <= tbl_flg_d[i];
         end
      end
   end

   // Sticky flags and trap report next state
   always_comb begin
      fflags_d  = (csr_wr ? csr_wdata : fflags_q) | acc_flg[4:0];
      exc_rob_d = trap ? trap_rob : exc_rob_q;
   end

   // Sticky flags and trap report registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fflags_q    <= '0;
         exc_valid_q <= 1'b0;
         exc_rob_q   <= '0;
      end else begin
         fflags_q    <= fflags_d;
         exc_valid_q <= trap;
         exc_rob_q   <= exc_rob_d;
      end
   end

   assign fflags    = fflags_q;
   assign exc_valid = exc_valid_q;
   assign exc_rob   = exc_rob_q;

endmodule

// File: tb/tb_fp_flag_collect.sv
// Directed bench for fp_flag_collect: hand-computed vectors, checked on negedge.
module tb_fp_flag_collect;

   localparam int unsigned ROB_W = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             u1_en, u3_en, u5_en;
   logic [ROB_W-1:0] u1_rob, u3_rob, u5_rob;
   logic [5:0]       u1_flg, u3_flg, u5_flg;
   logic [2:0]       ret_en;
   logic [ROB_W-1:0] ret_rob0, ret_rob1, ret_rob2;
   logic             flush;
   logic             csr_wr;
   logic [4:0]       csr_wdata;
   logic [4:0]       fflags;
   logic             exc_valid;
   logic [ROB_W-1:0] exc_rob;

   int n_checks = 0;
   int n_pass   = 0;

   fp_flag_collect #(.ROB_W(ROB_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .u1_en     (u1_en),
      .u1_rob    (u1_rob),
      .u1_flg    (u1_flg),
      .u3_en     (u3_en),
      .u3_rob    (u3_rob),
      .u3_flg    (u3_flg),
      .u5_en     (u5_en),
      .u5_rob    (u5_rob),
      .u5_flg    (u5_flg),
      .ret_en    (ret_en),
      .ret_rob0  (ret_rob0),
      .ret_rob1  (ret_rob1),
      .ret_rob2  (ret_rob2),
      .flush     (flush),
      .csr_wr    (csr_wr),
      .csr_wdata (csr_wdata),
      .fflags    (fflags),
      .exc_valid (exc_valid),
      .exc_rob   (exc_rob)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle();
      u1_en = 0; u3_en = 0; u5_en = 0;
      ret_en = 3'b000; flush = 0; csr_wr = 0; csr_wdata = '0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic ret1(input logic [ROB_W-1:0] r);
      ret_en = 3'b001; ret_rob0 = r;
   endtask

   task automatic csr_clear();
      csr_wr = 1; csr_wdata = 5'h00;
   endtask

   initial begin
      rst = 0;
      u1_rob = '0; u3_rob = '0; u5_rob = '0;
      u1_flg = '0; u3_flg = '0; u5_flg = '0;
      ret_rob0 = '0; ret_rob1 = '0; ret_rob2 = '0;
      idle();
      step(); step();
      check("rst_fflags", 32'(fflags), 32'h00);
      check("rst_exc_valid", 32'(exc_valid), 32'h0);
      check("rst_exc_rob", 32'(exc_rob), 32'h0);
      rst = 1;
      step();

      // Basic accrual from the table
      u1_en = 1; u1_rob = 5; u1_flg = 6'h01;
      step(); idle(); step();
      ret1(5);
      step(); idle();
      check("basic_fflags", 32'(fflags), 32'h01);
      check("basic_no_exc", 32'(exc_valid), 32'h0);
      csr_clear(); ret1(5);
      step(); idle();
      check("basic_entry_cleared", 32'(fflags), 32'h00);

      // Bypass merge of two lanes
      u3_en = 1; u3_rob = 9; u3_flg = 6'h02;
      u5_en = 1; u5_rob = 9; u5_flg = 6'h10;
      step(); idle();
      ret1(9);
      step(); idle();
      check("bypass_merge", 32'(fflags), 32'h12);

      // Three-lane collision merged in the table
      csr_clear();
      u1_en = 1; u1_rob = 10; u1_flg = 6'h01;
      u3_en = 1; u3_rob = 10; u3_flg = 6'h02;
      u5_en = 1; u5_rob = 10; u5_flg = 6'h08;
      step(); idle(); step();
      ret1(10);
      step(); idle();
      check("table_merge", 32'(fflags), 32'h0B);

      // Ordered trap in slot 1
      csr_clear();
      u1_en = 1; u1_rob = 1; u1_flg = 6'h04;
      u3_en = 1; u3_rob = 2; u3_flg = 6'h21;
      u5_en = 1; u5_rob = 3; u5_flg = 6'h08;
      step(); idle(); step();
      ret_en = 3'b111; ret_rob0 = 1; ret_rob1 = 2; ret_rob2 = 3;
      step(); idle();
      check("trap_fflags", 32'(fflags), 32'h05);
      check("trap_valid", 32'(exc_valid), 32'h1);
      check("trap_rob", 32'(exc_rob), 32'd2);
      step();
      check("trap_pulse_end", 32'(exc_valid), 32'h0);

      // Back-to-back traps, second one behind a non-FP op in slot 0
      u1_en = 1; u1_rob = 20; u1_flg = 6'h20;
      u3_en = 1; u3_rob = 21; u3_flg = 6'h20;
      step(); idle(); step();
      ret1(20);
      step();
      check("b2b_first_valid", 32'(exc_valid), 32'h1);
      check("b2b_first_rob", 32'(exc_rob), 32'd20);
      ret_en = 3'b011; ret_rob0 = 30; ret_rob1 = 21;
      step(); idle();
      check("b2b_second_valid", 32'(exc_valid), 32'h1);
      check("b2b_second_rob", 32'(exc_rob), 32'd21);
      check("b2b_fflags_kept", 32'(fflags), 32'h05);
      step();
      check("b2b_pulse_end", 32'(exc_valid), 32'h0);

      // CSR write colliding with retire
      csr_wr = 1; csr_wdata = 5'h1F;
      step(); idle();
      check("csr_write", 32'(fflags), 32'h1F);
      u1_en = 1; u1_rob = 12; u1_flg = 6'h01;
      step(); idle(); step();
      csr_clear(); ret1(12);
      step(); idle();
      check("csr_collision", 32'(fflags), 32'h01);

      // Flush while S1 holds a pending write
      csr_clear();
      u1_en = 1; u1_rob = 7; u1_flg = 6'h21;
      step(); idle();
      flush = 1;
      step(); idle();
      ret1(7);
      step(); idle();
      check("flush_fflags", 32'(fflags), 32'h00);
      check("flush_no_exc", 32'(exc_valid), 32'h0);

      // Flush beats a same-cycle lane write
      u1_en = 1; u1_rob = 8; u1_flg = 6'h02; flush = 1;
      step(); idle();
      ret1(8);
      step(); idle();
      check("flush_beats_lane", 32'(fflags), 32'h00);

      // Flush does not suppress a same-cycle retire
      u1_en = 1; u1_rob = 15; u1_flg = 6'h04;
      step(); idle(); step();
      flush = 1; ret1(15);
      step(); idle();
      check("flush_keeps_retire", 32'(fflags), 32'h04);

      // Same-edge S1 write beats the retire clear
      csr_clear();
      u1_en = 1; u1_rob = 40; u1_flg = 6'h08;
      step(); idle();
      ret1(40);
      step(); idle();
      check("bypass_retire", 32'(fflags), 32'h08);
      csr_clear(); ret1(40);
      step(); idle();
      check("s1_write_beats_clear", 32'(fflags), 32'h08);
      csr_clear(); ret1(40);
      step(); idle();
      check("entry40_cleared", 32'(fflags), 32'h00);

      // Async reset mid-stream with pending table content and a live trap pulse
      u1_en = 1; u1_rob = 60; u1_flg = 6'h02;
      step(); idle(); step();
      u3_en = 1; u3_rob = 50; u3_flg = 6'h21;
      step(); idle(); step();
      ret1(50);
      step(); idle();
      check("pre_rst_fflags", 32'(fflags), 32'h01);
      check("pre_rst_exc_valid", 32'(exc_valid), 32'h1);
      check("pre_rst_exc_rob", 32'(exc_rob), 32'd50);
      #2 rst = 0;
      #1;
      check("async_rst_fflags", 32'(fflags), 32'h00);
      check("async_rst_exc_valid", 32'(exc_valid), 32'h0);
      check("async_rst_exc_rob", 32'(exc_rob), 32'h0);
      @(negedge clk);
      rst = 1;
      step();
      ret1(60);
      step(); idle();
      check("rst_clears_table", 32'(fflags), 32'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1);
   end

endmodule
